// File: rtl/pps_monitor.sv
// pps_monitor
//   Receive side of a 1 Hz PPS/blink link. Synchronizes an external
//   pulse-per-second input, measures the number of i_clk cycles between
//   successive rising edges and reports the period, a lock indication and
//   a sticky loss-of-signal flag.
//
// Ports
//   i_clk      in   1   system clock
//   i_reset_n  in   1   asynchronous, active-low reset
//   i_pps      in   1   PPS input, asynchronous to i_clk
//   o_stb      out  1   one-cycle pulse per detected rising edge of i_pps
//   o_valid    out  1   one-cycle pulse: o_period updated this cycle
//   o_period   out  CW  cycles between the last two detected edges
//   o_locked   out  1   LOCK_COUNT consecutive good periods seen
//   o_lost     out  1   no edge within CLOCK_RATE_HZ+TOLERANCE cycles (sticky)
//   o_err_cnt  out  16  saturating count of bad periods

module pps_monitor #(
  parameter int CLOCK_RATE_HZ = 12_000_000,
  parameter int TOLERANCE     = 1_200,
  parameter int LOCK_COUNT    = 4,
  parameter int CW            = 32
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_pps,
  output logic          o_stb,
  output logic          o_valid,
  output logic [CW-1:0] o_period,
  output logic          o_locked,
  output logic          o_lost,
  output logic [15:0]   o_err_cnt
);

  localparam int GW = $clog2(LOCK_COUNT + 1);

  // Largest counter value before the reference is declared lost.
  localparam logic [CW-1:0] LIMIT   = CW'(CLOCK_RATE_HZ + TOLERANCE);
  localparam logic [CW-1:0] GOOD_LO = CW'((CLOCK_RATE_HZ > TOLERANCE) ?
                                          (CLOCK_RATE_HZ - TOLERANCE) : 0);
  localparam logic [CW-1:0] GOOD_HI = CW'(CLOCK_RATE_HZ + TOLERANCE);
  localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    LOCKED
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] counter, counter_next;
  logic [GW-1:0] good_cnt, good_next;
  logic [CW-1:0] period_next;
  logic [15:0]   err_next;
  logic          locked_next, lost_next, stb_next, valid_next;

  logic          sync_meta, sync_pps, pps_prev;
  logic          pps_rise;
  logic [CW-1:0] period_meas;
  logic          period_good;
  logic          timeout;

  // Two-flop synchronizer plus edge-history flop. All three reset high so
  // an input already high at reset release is not mistaken for a rise.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_meta <= 1'b1;
      sync_pps  <= 1'b1;
      pps_prev  <= 1'b1;
    end else begin
      sync_meta <= i_pps;
      sync_pps  <= sync_meta;
      pps_prev  <= sync_pps;
    end
  end

  assign pps_rise    = sync_pps & ~pps_prev;
  assign period_meas = counter + CW'(1);
  assign period_good = (period_meas >= GOOD_LO) && (period_meas <= GOOD_HI);
  assign timeout     = (counter == LIMIT);

  // Next-state and output logic. An edge always takes priority over a
  // timeout landing on the same cycle, so that period is still reported.
  always_comb begin
    state_next   = state;
    counter_next = counter;
    good_next    = good_cnt;
    period_next  = o_period;
    err_next     = o_err_cnt;
    locked_next  = o_locked;
    lost_next    = o_lost;
    stb_next     = 1'b0;
    valid_next   = 1'b0;

    case (state)
      IDLE: begin
        // The counter is parked at zero until a reference edge arrives.
        if (pps_rise) begin
          state_next   = TRACK;
          stb_next     = 1'b1;
          lost_next    = 1'b0;
          counter_next = '0;
        end
      end

      TRACK, LOCKED: begin
        if (pps_rise) begin
          stb_next     = 1'b1;
          valid_next   = 1'b1;
          period_next  = period_meas;
          counter_next = '0;
          if (period_good) begin
            if (state == TRACK) begin
              if (good_cnt == LOCK_LAST) begin
                state_next  = LOCKED;
                locked_next = 1'b1;
              end else begin
                good_next = good_cnt + GW'(1);
              end
            end
          end else begin
            state_next  = TRACK;
            locked_next = 1'b0;
            good_next   = '0;
            err_next    = (o_err_cnt == 16'hFFFF) ? o_err_cnt : o_err_cnt + 16'd1;
          end
        end else if (timeout) begin
          state_next   = IDLE;
          lost_next    = 1'b1;
          locked_next  = 1'b0;
          good_next    = '0;
          counter_next = '0;
        end else begin
          counter_next = counter + CW'(1);
        end
      end

      default: begin
        state_next   = IDLE;
        counter_next = '0;
        good_next    = '0;
      end
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      counter   <= '0;
      good_cnt  <= '0;
      o_period  <= '0;
      o_err_cnt <= '0;
      o_locked  <= 1'b0;
      o_lost    <= 1'b0;
      o_stb     <= 1'b0;
      o_valid   <= 1'b0;
    end else begin
      state     <= state_next;
      counter   <= counter_next;
      good_cnt  <= good_next;
      o_period  <= period_next;
      o_err_cnt <= err_next;
      o_locked  <= locked_next;
      o_lost    <= lost_next;
      o_stb     <= stb_next;
      o_valid   <= valid_next;
    end
  end

  // The counter is bounded by the timeout limit.
  counter_bound: assert property (@(posedge i_clk) disable iff (!i_reset_n)
                                  counter <= LIMIT);

endmodule

// File: tb/tb_pps_monitor.sv
// tb_pps_monitor
//   Self-checking bench for pps_monitor (CLOCK_RATE_HZ=1000, TOLERANCE=10,
//   LOCK_COUNT=3). A behavioural model tracks detected edges by absolute
//   cycle number and derives period, lock, loss and error count from the
//   elapsed time between detections.

module tb_pps_monitor;

  localparam int RATE  = 1000;
  localparam int TOL   = 10;
  localparam int LOCK  = 3;
  localparam int CW    = 32;
  localparam int LIMIT = RATE + TOL;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          pps;
  logic          stb;
  logic          valid;
  logic [CW-1:0] period;
  logic          locked;
  logic          lost;
  logic [15:0]   err_cnt;

  pps_monitor #(
    .CLOCK_RATE_HZ(RATE),
    .TOLERANCE(TOL),
    .LOCK_COUNT(LOCK),
    .CW(CW)
  ) dut (
    .i_clk(clk),
    .i_reset_n(reset_n),
    .i_pps(pps),
    .o_stb(stb),
    .o_valid(valid),
    .o_period(period),
    .o_locked(locked),
    .o_lost(lost),
    .o_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Cycles at which a rise is expected to be reported on o_stb.
  int det_q[$];

  bit m_have_ref;
  bit m_lost;
  bit m_locked;
  bit exp_stb;
  bit exp_valid;
  int m_streak;
  int m_err;
  int m_period;
  int m_last;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_have_ref = 1'b0;
    m_lost     = 1'b0;
    m_locked   = 1'b0;
    exp_stb    = 1'b0;
    exp_valid  = 1'b0;
    m_streak   = 0;
    m_err      = 0;
    m_period   = 0;
    m_last     = 0;
    det_q.delete();
  endtask

  // Advance the model to the current cycle.
  task automatic modelStep();
    int g;
    int d;
    int dropped;
    exp_stb   = 1'b0;
    exp_valid = 1'b0;
    if (det_q.size() > 0 && det_q[0] == cyc) begin
      dropped = det_q.pop_front();
      exp_stb = 1'b1;
      if (!m_have_ref) begin
        m_have_ref = 1'b1;
        m_lost     = 1'b0;
      end else begin
        g         = cyc - m_last;
        exp_valid = 1'b1;
        m_period  = g;
        d         = (g > RATE) ? g - RATE : RATE - g;
        if (d <= TOL) begin
          m_streak++;
          if (m_streak >= LOCK) m_locked = 1'b1;
        end else begin
          m_streak = 0;
          m_locked = 1'b0;
          if (m_err < 65535) m_err++;
        end
      end
      m_last = cyc;
    end else if (m_have_ref && (cyc - m_last) == LIMIT + 1) begin
      m_lost     = 1'b1;
      m_locked   = 1'b0;
      m_streak   = 0;
      m_have_ref = 1'b0;
    end
  endtask

  task automatic checkAll();
    checkOutput("stb", 32'(stb), 32'(exp_stb));
    checkOutput("valid", 32'(valid), 32'(exp_valid));
    checkOutput("lost", 32'(lost), 32'(m_lost));
    checkOutput("locked", 32'(locked), 32'(m_locked));
    checkOutput("err_cnt", 32'(err_cnt), 32'(m_err));
    checkOutput("period", period, 32'(m_period));
  endtask

  // One clock: sample 1 time unit after the rising edge, then compare.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (reset_n) modelStep();
    else modelReset();
    checkAll();
  endtask

  // Raise PPS now, keep it high for width cycles, low for the rest of gap.
  // The next call therefore produces a rise gap cycles after this one.
  task automatic applyStimulus(input int gap, input int width);
    pps = 1'b1;
    det_q.push_back(cyc + 3);
    repeat (width) tick();
    pps = 1'b0;
    repeat (gap - width) tick();
  endtask

  function automatic int pickWidth(input int gap);
    int hi;
    hi = gap - 2;
    if (hi > 200) hi = 200;
    return int'($urandom_range(hi, 2));
  endfunction

  initial begin
    int gap;
    int sel;

    modelReset();
    reset_n = 1'b0;
    pps     = 1'b1;

    // Reset with PPS held high across release: no edge must appear.
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (5) tick();
    pps = 1'b0;
    repeat (6) tick();

    // Steady 1000-cycle reference, then one 1011 period while locked,
    // then three 990 periods to relock.
    $display("[TB] nominal lock and relock");
    for (int i = 0; i < 4; i++) applyStimulus(1000, pickWidth(1000));
    applyStimulus(1011, pickWidth(1011));
    for (int i = 0; i < 3; i++) applyStimulus(990, pickWidth(990));

    // Reference stops after lock: loss of signal, then a fresh reference.
    $display("[TB] loss of signal");
    applyStimulus(1200, pickWidth(1200));
    applyStimulus(1000, pickWidth(1000));

    // Runt period, then asynchronous reset in the middle of a period.
    $display("[TB] runt period and mid-period reset");
    applyStimulus(500, pickWidth(500));
    applyStimulus(300, 50);
    #2;
    reset_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async_rst_stb", 32'(stb), 32'd0);
    checkOutput("async_rst_valid", 32'(valid), 32'd0);
    checkOutput("async_rst_locked", 32'(locked), 32'd0);
    checkOutput("async_rst_lost", 32'(lost), 32'd0);
    checkOutput("async_rst_err", 32'(err_cnt), 32'd0);
    checkOutput("async_rst_period", period, 32'd0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (5) tick();

    // Edge landing exactly on the timeout cycle.
    $display("[TB] edge on timeout cycle");
    applyStimulus(1000, pickWidth(1000));
    applyStimulus(1011, pickWidth(1011));
    applyStimulus(1000, pickWidth(1000));

    // Randomized mix of good, runt, boundary and timed-out periods.
    $display("[TB] randomized periods");
    for (int i = 0; i < 10; i++) begin
      sel = int'($urandom_range(3, 0));
      case (sel)
        0:       gap = int'($urandom_range(RATE + TOL, RATE - TOL));
        1:       gap = int'($urandom_range(900, 20));
        2:       gap = LIMIT + 1;
        default: gap = int'($urandom_range(1150, LIMIT + 2));
      endcase
      applyStimulus(gap, pickWidth(gap));
    end
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
